// File: rtl/a600_fastram_ctrl.sv
// a600_fastram_ctrl: 68000 FastRAM controller for 1/2/4 x 2MB DRAM banks
// with CBR refresh backlog and Zorro II autoconfig.
module a600_fastram_ctrl #(
  parameter int         NUM_BANKS     = 4,
  parameter int         MA_WIDTH      = 10,
  parameter int         RFSH_INTERVAL = 108,
  parameter logic [3:0] PROD_ID       = 4'h3
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_nreset,
  input  logic [23:1]          cpu_a,
  input  logic [3:0]           cpu_d_in,
  output logic [3:0]           cpu_d_out,
  output logic                 cpu_d_oe,
  input  logic                 cpu_nas,
  input  logic                 cpu_nlds,
  input  logic                 cpu_nuds,
  input  logic                 cpu_rnw,
  input  logic                 cfg_en,
  output logic [NUM_BANKS-1:0] dram_nras,
  output logic                 dram_nlcas,
  output logic                 dram_nucas,
  output logic [MA_WIDTH-1:0]  dram_ma,
  output logic                 rfsh_busy
);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, PRE, CBR1, CBR2, CBR3
  } state_t;

  localparam int TW = $clog2(RFSH_INTERVAL + 1);
  localparam logic [TW-1:0] T_INIT = TW'(RFSH_INTERVAL);
  localparam logic [TW-1:0] T_LOAD = TW'(RFSH_INTERVAL - 1);
  localparam logic [3:0] NB = 4'(NUM_BANKS);
  localparam logic [3:0] SIZE =
    (NUM_BANKS == 1) ? 4'h6 : (NUM_BANKS == 2) ? 4'h7 : 4'h0;
  localparam logic [NUM_BANKS-1:0] BANK_ONE = NUM_BANKS'(1);

  state_t                 state;
  logic [NUM_BANKS-1:0]   ras_q;
  logic                   cbr_cas_n;
  logic [TW-1:0]          tmr;
  logic [1:0]             backlog;
  logic [1:0]             backlog_nx;
  logic [2:0]             base;
  logic                   configured;
  logic                   autoconf_on;
  logic                   wr_seen;

  logic                   expire;
  logic                   take_rf;
  logic [3:0]             off;
  logic                   hit;
  logic                   ac_sel;
  logic                   ac_wr;
  logic [5:0]             reg_a;
  logic [3:0]             nib;
  logic                   acc;
  logic                   unused;

  assign unused = cpu_d_in[0];

  // Base A20 is dropped; extra top bit keeps wrap-around from aliasing
  assign off = {1'b0, cpu_a[23:21]} - {1'b0, base};
  assign hit = configured & (off < NB);

  assign ac_sel = autoconf_on & cfg_en & (cpu_a[23:16] == 8'hE8);
  assign reg_a  = cpu_a[6:1];
  assign ac_wr  = ac_sel & ~cpu_nas & ~cpu_rnw & ~wr_seen;

  always_comb begin
    nib = 4'hF;
    unique case (reg_a)
      6'h00:                         nib = 4'hE;
      6'h01:                         nib = SIZE;
      6'h04:                         nib = ~PROD_ID;
      6'h02, 6'h03, 6'h08,
      6'h09, 6'h0A, 6'h0B:           nib = 4'hE;
      6'h20, 6'h21:                  nib = 4'h0;
      default:                       nib = 4'hF;
    endcase
  end

  assign cpu_d_oe  = ac_sel & cpu_rnw & ~cpu_nas;
  assign cpu_d_out = cpu_d_oe ? nib : 4'hF;

  assign expire  = (tmr == '0);
  assign take_rf = (state == IDLE) & cpu_nas & (backlog != 2'd0);

  always_comb begin
    backlog_nx = backlog;
    if (expire && !take_rf && backlog != 2'd3)
      backlog_nx = backlog + 2'd1;
    else if (!expire && take_rf)
      backlog_nx = backlog - 2'd1;
  end

  always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
    if (!cpu_nreset) begin
      state       <= IDLE;
      ras_q       <= '1;
      cbr_cas_n   <= 1'b1;
      tmr         <= T_INIT;
      backlog     <= 2'd0;
      base        <= 3'd0;
      configured  <= 1'b0;
      autoconf_on <= 1'b1;
      wr_seen     <= 1'b0;
    end else begin
      tmr     <= expire ? T_LOAD : tmr - TW'(1);
      backlog <= backlog_nx;

      unique case (state)
        IDLE: begin
          if (!cpu_nas && hit) begin
            state <= ROW;
            ras_q <= ~(BANK_ONE << off[2:0]);
          end else if (take_rf) begin
            state     <= CBR1;
            cbr_cas_n <= 1'b0;
          end
        end
        ROW: state <= COL;
        COL: begin
          if (cpu_nas) begin
            state <= PRE;
            ras_q <= '1;
          end
        end
        PRE: state <= IDLE;
        CBR1: begin
          state <= CBR2;
          ras_q <= '0;
        end
        CBR2: begin
          state     <= CBR3;
          ras_q     <= '1;
          cbr_cas_n <= 1'b1;
        end
        CBR3: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (cpu_nas)
        wr_seen <= 1'b0;
      else if (!cpu_rnw)
        wr_seen <= 1'b1;

      if (ac_wr && reg_a == 6'h24) begin
        base        <= cpu_d_in[3:1];
        configured  <= 1'b1;
        autoconf_on <= 1'b0;
      end else if (ac_wr && reg_a == 6'h26) begin
        autoconf_on <= 1'b0;
      end
    end
  end

  // /AS rising releases the strobes without waiting for the clock
  assign acc = (state == ROW) | (state == COL);
  assign dram_nras = ras_q | {NUM_BANKS{cpu_nas & acc}};
  assign dram_nlcas = (state == COL) ? (cpu_nlds | cpu_nas) : cbr_cas_n;
  assign dram_nucas = (state == COL) ? (cpu_nuds | cpu_nas) : cbr_cas_n;
  assign dram_ma = (state == COL) ? cpu_a[MA_WIDTH:1]
                                  : cpu_a[MA_WIDTH+10:11];
  assign rfsh_busy = (state == CBR1) | (state == CBR2) | (state == CBR3);

endmodule
